// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: camera-style vsync/href/clken frame source
// fed from a valid/ready pixel stream; all framing outputs are registered.
module pixel_stream_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int H_BLANK    = 160,
  parameter int VSYNC_LEN  = 4,
  parameter int V_BACK     = 10,
  parameter int V_FRONT    = 10,
  parameter int CLK_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic                  post_frame_clken,
  output logic [DATA_WIDTH-1:0] post_img_y,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int M1   = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int M2   = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
  localparam int BMAX = (M1 > M2) ? M1 : M2;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam int XW   = $clog2(IMG_WIDTH + 1);
  localparam int YW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DW   = $clog2(CLK_DIV) + 1;

  typedef enum logic [2:0] {
    IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP, DONE
  } state_t;

  state_t          state;
  logic [BW-1:0]   cnt;
  logic [BW-1:0]   cnt_last;
  logic [XW-1:0]   col;
  logic [YW-1:0]   row;
  logic [DW-1:0]   div_cnt;
  logic            xfer;
  logic            blank_end;
  logic            line_end;
  logic            last_row;

  assign in_ready  = (state == ACTIVE) && (div_cnt == '0);
  assign xfer      = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign last_row  = (row == YW'(IMG_HEIGHT - 1));
  assign blank_end = (cnt == cnt_last);

  // With CLK_DIV>1 the line keeps its last pixel slot open until the
  // divider drains, so every line spans IMG_WIDTH*CLK_DIV cycles.
  assign line_end = (CLK_DIV == 1)
    ? (xfer && (col == XW'(IMG_WIDTH - 1)))
    : ((col == XW'(IMG_WIDTH)) && (div_cnt == DW'(1)));

  always_comb begin
    cnt_last = BW'(V_FRONT - 1);
    unique case (1'b1)
      (state == VSYNC):  cnt_last = BW'(VSYNC_LEN - 1);
      (state == VBP):    cnt_last = BW'(V_BACK - 1);
      (state == HBLANK): cnt_last = BW'(H_BLANK - 1);
      default:           cnt_last = BW'(V_FRONT - 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      col              <= '0;
      row              <= '0;
      div_cnt          <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_y       <= '0;
      frame_done       <= 1'b0;
    end else begin
      post_frame_vsync <= (state == VSYNC);
      post_frame_href  <= (state == ACTIVE);
      post_frame_clken <= xfer;
      frame_done       <= (state == DONE);
      if (xfer)
        post_img_y <= in_data;
      else if (state != ACTIVE)
        post_img_y <= '0;
      if (xfer)
        div_cnt <= DW'(CLK_DIV - 1);
      else if (div_cnt != '0)
        div_cnt <= div_cnt - DW'(1);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (en) state <= VSYNC;
        end
        VSYNC: begin
          cnt <= blank_end ? '0 : cnt + BW'(1);
          if (blank_end) state <= VBP;
        end
        VBP: begin
          cnt <= blank_end ? '0 : cnt + BW'(1);
          if (blank_end) begin
            state <= ACTIVE;
            col   <= '0;
            row   <= '0;
          end
        end
        ACTIVE: begin
          cnt <= '0;
          if (xfer) col <= col + XW'(1);
          if (line_end) state <= HBLANK;
        end
        HBLANK: begin
          cnt <= blank_end ? '0 : cnt + BW'(1);
          if (blank_end) begin
            if (last_row) begin
              state <= VFP;
            end else begin
              state <= ACTIVE;
              row   <= row + YW'(1);
              col   <= '0;
            end
          end
        end
        VFP: begin
          cnt <= blank_end ? '0 : cnt + BW'(1);
          if (blank_end) state <= DONE;
        end
        DONE: begin
          cnt   <= '0;
          state <= en ? VSYNC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// tb_pixel_stream_gen: directed frames on a 4x3 image, scoreboarded
// pixel data, frame timing model, stalls, en drop and async reset.
module tb_pixel_stream_gen;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int HB    = 2;
  localparam int VS    = 2;
  localparam int VB    = 2;
  localparam int VF    = 2;
  localparam int FRAME = VS + VB + H * (W + HB) + VF + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, vld = 1'b0, rdy;
  logic [7:0] din = '0, y;
  logic       vs, hr, ck, fd, bsy;
  logic       en2 = 1'b0, vld2 = 1'b0, rdy2;
  logic [7:0] din2 = '0, y2;
  logic       vs2, hr2, ck2, fd2, bsy2;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q[$];
  logic [7:0] q2[$];
  int         pix = 0, pix2 = 0;
  bit         took = 0, took2 = 0;
  bit         en_n = 0, vld_n = 0, en2_n = 0, vld2_n = 0;
  int         pops = 0, pops2 = 0;
  logic [7:0] last_pop = '0, last_pop2 = '0;
  int         run = 0, rck = 0, last_run = 0, last_ck = 0, runs = 0;
  int         n2, g;

  always #5 clk = ~clk;

  pixel_stream_gen #(
    .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB),
    .VSYNC_LEN(VS), .V_BACK(VB), .V_FRONT(VF), .CLK_DIV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(vld), .in_ready(rdy), .in_data(din),
    .post_frame_vsync(vs), .post_frame_href(hr),
    .post_frame_clken(ck), .post_img_y(y),
    .frame_done(fd), .busy(bsy)
  );

  pixel_stream_gen #(
    .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB),
    .VSYNC_LEN(VS), .V_BACK(VB), .V_FRONT(VF), .CLK_DIV(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2),
    .in_valid(vld2), .in_ready(rdy2), .in_data(din2),
    .post_frame_vsync(vs2), .post_frame_href(hr2),
    .post_frame_clken(ck2), .post_img_y(y2),
    .frame_done(fd2), .busy(bsy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {vsync, href, clken, frame_done} t cycles after vsync rise,
  // for a frame with a continuously valid source.
  function automatic logic [3:0] exp_trace(input int t);
    int  u;
    int  s;
    bit  h;
    u = t % FRAME;
    h = 1'b0;
    for (int l = 0; l < H; l++) begin
      s = VS + VB + l * (W + HB);
      if (u >= s && u < s + W) h = 1'b1;
    end
    return {(u < VS), h, h, (u == FRAME - 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (took) pix++;
    if (took2) pix2++;
    took  = 0;
    took2 = 0;
    en    = en_n;
    vld   = vld_n;
    din   = 8'(pix);
    en2   = en2_n;
    vld2  = vld2_n;
    din2  = 8'(pix2);
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      q2.delete();
    end else begin
      if (ck) begin
        chk("sb1_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          last_pop = q.pop_front();
          pops++;
          chk("pixel1", y, last_pop);
        end
      end
      if (!hr) chk("y_blank", y, 0);
      chk("vs_href_excl", vs & hr, 0);
      if (hr) begin
        run++;
        if (ck) rck++;
      end else if (run != 0) begin
        last_run = run;
        last_ck  = rck;
        runs++;
        run = 0;
        rck = 0;
      end
      if (vld && rdy) begin
        q.push_back(din);
        took = 1;
      end
      if (ck2) begin
        chk("sb2_nonempty", q2.size() != 0, 1);
        if (q2.size() != 0) begin
          last_pop2 = q2.pop_front();
          pops2++;
          chk("pixel2", y2, last_pop2);
        end
      end
      chk("vs2_href2_excl", vs2 & hr2, 0);
      if (vld2 && rdy2) begin
        q2.push_back(din2);
        took2 = 1;
      end
    end
  endtask

  initial begin
    // reset holds everything low even with en and valid high
    en_n  = 1;
    vld_n = 1;
    repeat (3) tick();
    chk("rst_ctrl", {vs, hr, ck, fd, bsy, rdy}, 0);
    chk("rst_y", y, 0);
    chk("rst_ctrl2", {vs2, hr2, ck2, fd2, bsy2, rdy2}, 0);
    rst_n = 1;
    tick();
    chk("busy_after_release", bsy, 1);
    chk("vsync_not_yet", vs, 0);
    tick();
    chk("vsync_rise", vs, 1);

    // full frame with continuous data, then back-to-back vsync
    pops = 0;
    for (int t = 0; t <= FRAME; t++) begin
      if (t > 0) tick();
      chk($sformatf("trace_t%0d", t), {vs, hr, ck, fd}, exp_trace(t));
    end
    chk("frame1_pixels", pops, W * H);
    chk("frame1_last", last_pop, 8'd11);

    // stall after pixel 1 of line 0, then drop en during line 1
    pops = 0;
    runs = 0;
    for (g = 0; g < 40 && !(took && pix == 13); g++) tick();
    chk("reach_pixel13", pix, 13);
    vld_n = 0;
    repeat (3) tick();
    vld_n = 1;
    for (g = 0; g < 40 && runs < 1; g++) tick();
    chk("stall_href_len", last_run, 7);
    chk("stall_clken_cnt", last_ck, W);
    for (g = 0; g < 10 && !hr; g++) tick();
    chk("line1_start", hr, 1);
    en_n = 0;
    for (g = 0; g < 60 && !fd; g++) tick();
    chk("frame2_done", fd, 1);
    chk("frame2_busy_at_done", bsy, 0);
    chk("frame2_pixels", pops, W * H);
    chk("frame2_last", last_pop, 8'd23);
    chk("frame2_lines", runs, H);
    chk("frame2_line_len", last_run, W);
    tick();
    chk("idle_after_done", {vs, hr, fd, bsy}, 0);
    repeat (3) tick();
    chk("stays_idle", {vs, bsy}, 0);

    // restart from IDLE, then async reset in the middle of line 2
    en_n = 1;
    runs = 0;
    tick();
    tick();
    chk("restart_busy", bsy, 1);
    tick();
    chk("restart_vsync", vs, 1);
    for (g = 0; g < 60 && !(runs == 2 && hr); g++) tick();
    chk("line2_start", hr, 1);
    tick();
    #2 rst_n = 0;
    #1;
    chk("async_rst_ctrl", {vs, hr, ck, fd, bsy, rdy}, 0);
    chk("async_rst_y", y, 0);
    took = 0;
    pix  = 0;
    run  = 0;
    rck  = 0;
    runs = 0;
    pops = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    tick();
    chk("fresh_vsync", vs, 1);
    en_n = 0;
    for (g = 0; g < 60 && !fd; g++) tick();
    chk("fresh_done", fd, 1);
    chk("fresh_pixels", pops, W * H);
    chk("fresh_last", last_pop, 8'd11);

    // CLK_DIV=2 instance: ready alternates, line spans 8 cycles
    en2_n  = 1;
    vld2_n = 1;
    for (g = 0; g < 20 && !hr2; g++) tick();
    chk("div2_href", hr2, 1);
    n2 = 0;
    for (int i = 0; i < 20 && hr2; i++) begin
      if (n2 < 7) begin
        chk($sformatf("div2_ready_%0d", n2), rdy2, 32'(n2 % 2));
        chk($sformatf("div2_clken_%0d", n2), ck2, 32'(n2 % 2 == 0));
      end
      n2++;
      tick();
    end
    chk("div2_href_len", n2, 2 * W);
    en2_n = 0;
    for (g = 0; g < 120 && !fd2; g++) tick();
    chk("div2_done", fd2, 1);
    chk("div2_pixels", pops2, W * H);
    chk("div2_last", last_pop2, 8'd11);
    tick();
    chk("div2_idle", bsy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
